atmr_vote_monitor: RTL and testbench

Registered majority voter and replica-health monitor for the ATMR benchmark circuits. It sits directly downstream of the three replicas (ori, mai, men) of an ATMR netlist. It captures their output words, produces the bitwise majority word on a 2-stage pipeline, and tracks which replica disagrees with the majority. Fault status and per-replica error counts are exposed for the test harness.

---
 rtl/atmr_vote_monitor.sv | 172 +++++++++++++++++
 tb/tb_atmr_vote_monitor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/atmr_vote_monitor.sv
// Registered 3-way majority voter with per-replica mismatch counters and a health FSM.
// 2-cycle latency, 1 sample/cycle, no backpressure; optional care mask via ATMR_MON_MASK_EN.
module atmr_vote_monitor #(
   parameter int WIDTH   = 10,
   parameter int CNT_W   = 8,
   parameter int PERSIST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] ori_z,
   input  logic [WIDTH-1:0] mai_z,
   input  logic [WIDTH-1:0] men_z,
`ifdef ATMR_MON_MASK_EN
   input  logic [WIDTH-1:0] care_mask,
`endif
   input  logic             clr,
   output logic             out_valid,
   output logic [WIDTH-1:0] z,
   output logic [2:0]       mism,
   output logic [CNT_W-1:0] err_ori,
   output logic [CNT_W-1:0] err_mai,
   output logic [CNT_W-1:0] err_men,
   output logic [1:0]       fault_state,
   output logic [1:0]       fault_rep
);

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_SUSPECT = 2'd1,
      ST_FAULT   = 2'd2,
      ST_MULTI   = 2'd3
   } state_t;

   localparam logic [3:0] PERSIST_RUN = 4'(PERSIST);
   localparam logic [1:0] REP_NONE    = 2'd3;

   logic                        v1_q;
   logic [WIDTH-1:0]            ori_q, mai_q, men_q;
   logic [WIDTH-1:0]            care_q;
   logic                        ov_q;
   logic [WIDTH-1:0]            z_q;
   logic [2:0]                  mism_q;
   logic [2:0][CNT_W-1:0]       err_q;
   state_t                      state_q;
   logic [1:0]                  rep_q;
   logic [3:0]                  run_q;

   logic [WIDTH-1:0]            maj_c;
   logic [2:0]                  mism_c;
   logic [1:0]                  pop_c;
   logic [1:0]                  one_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q  <= 1'b0;
         ori_q <= '0;
         mai_q <= '0;
         men_q <= '0;
      end else begin
         v1_q <= in_valid;
         if (in_valid) begin
            ori_q <= ori_z;
            mai_q <= mai_z;
            men_q <= men_z;
         end
      end
   end

`ifdef ATMR_MON_MASK_EN
   // The mask travels with its sample so it always qualifies the same words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         care_q <= '0;
      end else if (in_valid) begin
         care_q <= care_mask;
      end
   end
`else
   assign care_q = {WIDTH{1'b1}};
`endif

   always_comb begin
      maj_c     = (ori_q & mai_q) | (ori_q & men_q) | (mai_q & men_q);
      mism_c[0] = |((ori_q ^ maj_c) & care_q);
      mism_c[1] = |((mai_q ^ maj_c) & care_q);
      mism_c[2] = |((men_q ^ maj_c) & care_q);
      pop_c     = 2'(mism_c[0]) + 2'(mism_c[1]) + 2'(mism_c[2]);
      case (mism_c)
         3'b001:  one_c = 2'd0;
         3'b010:  one_c = 2'd1;
         3'b100:  one_c = 2'd2;
         default: one_c = REP_NONE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ov_q   <= 1'b0;
         z_q    <= '0;
         mism_q <= '0;
      end else begin
         ov_q <= v1_q;
         if (v1_q) begin
            z_q    <= maj_c;
            mism_q <= mism_c;
         end
      end
   end

   // clr outranks a sample landing on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q   <= '0;
         state_q <= ST_OK;
         rep_q   <= REP_NONE;
         run_q   <= '0;
      end else if (clr) begin
         err_q   <= '0;
         state_q <= ST_OK;
         rep_q   <= REP_NONE;
         run_q   <= '0;
      end else if (v1_q) begin
         for (int r = 0; r < 3; r++) begin
            if (mism_c[r] && (err_q[r] != {CNT_W{1'b1}})) begin
               err_q[r] <= err_q[r] + CNT_W'(1);
            end
         end
         case (state_q)
            ST_OK: begin
               if (pop_c >= 2'd2) begin
                  state_q <= ST_MULTI;
               end else if (pop_c == 2'd1) begin
                  state_q <= ST_SUSPECT;
                  rep_q   <= one_c;
                  run_q   <= 4'd1;
               end
            end
            ST_SUSPECT: begin
               if (pop_c >= 2'd2) begin
                  state_q <= ST_MULTI;
                  rep_q   <= REP_NONE;
                  run_q   <= '0;
               end else if (pop_c == 2'd0) begin
                  state_q <= ST_OK;
                  rep_q   <= REP_NONE;
                  run_q   <= '0;
               end else if (one_c == rep_q) begin
                  run_q <= run_q + 4'd1;
                  if (run_q + 4'd1 == PERSIST_RUN) begin
                     state_q <= ST_FAULT;
                  end
               end else begin
                  rep_q <= one_c;
                  run_q <= 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid   = ov_q;
   assign z           = z_q;
   assign mism        = mism_q;
   assign err_ori     = err_q[0];
   assign err_mai     = err_q[1];
   assign err_men     = err_q[2];
   assign fault_state = state_q;
   assign fault_rep   = rep_q;

endmodule

// File: tb/tb_atmr_vote_monitor.sv
// Directed + randomized bench for atmr_vote_monitor against a streak-based reference model.
module tb_atmr_vote_monitor;
   localparam int W  = 10;
   localparam int CW = 8;
   localparam int P  = 4;
`ifdef ATMR_MON_MASK_EN
   localparam bit MASK_EN = 1'b1;
`else
   localparam bit MASK_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  ori_z = '0, mai_z = '0, men_z = '0, care_mask = '1;
   logic          clr = 1'b0;
   logic          out_valid;
   logic [W-1:0]  z;
   logic [2:0]    mism;
   logic [CW-1:0] err_ori, err_mai, err_men;
   logic [1:0]    fault_state, fault_rep;

   always #5 clk = ~clk;

   atmr_vote_monitor #(.WIDTH(W), .CNT_W(CW), .PERSIST(P)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .ori_z(ori_z), .mai_z(mai_z), .men_z(men_z),
`ifdef ATMR_MON_MASK_EN
      .care_mask(care_mask),
`endif
      .clr(clr), .out_valid(out_valid), .z(z), .mism(mism),
      .err_ori(err_ori), .err_mai(err_mai), .err_men(err_men),
      .fault_state(fault_state), .fault_rep(fault_rep)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: one pending sample (the stage between capture and result) plus health summary.
   bit           p_vld = 1'b0;
   logic [W-1:0] p_w [3];
   logic [W-1:0] p_m = '1;
   bit           exp_ov = 1'b0;
   logic [W-1:0] exp_z = '0;
   logic [2:0]   exp_mism = '0;
   int           exp_err [3];
   int           exp_state = 0;
   int           exp_rep = 3;
   int           streak = 0;

   function automatic logic [W-1:0] vote(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c);
      logic [W-1:0] res = '0;
      for (int i = 0; i < W; i++) begin
         int ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
         res[i] = (ones >= 2);
      end
      return res;
   endfunction

   function automatic logic [W-1:0] flip_maybe();
      logic [W-1:0] f = '0;
      if ($urandom_range(0, 5) == 0) f[$urandom_range(0, W-1)] = 1'b1;
      return f;
   endfunction

   task automatic model_health_clear();
      for (int r = 0; r < 3; r++) exp_err[r] = 0;
      exp_state = 0;
      exp_rep   = 3;
      streak    = 0;
   endtask

   task automatic model_edge(input bit clr_now);
      int nbad = 0;
      int who  = 3;
      if (p_vld) begin
         exp_z = vote(p_w[0], p_w[1], p_w[2]);
         for (int r = 0; r < 3; r++) exp_mism[r] = (((p_w[r] ^ exp_z) & p_m) != '0);
      end
      exp_ov = p_vld;
      if (clr_now) begin
         model_health_clear();
      end else if (p_vld) begin
         for (int r = 0; r < 3; r++) begin
            if (exp_mism[r]) begin
               nbad++;
               who = r;
               if (exp_err[r] < (1 << CW) - 1) exp_err[r]++;
            end
         end
         if (exp_state <= 1) begin
            if (nbad >= 2) begin
               exp_state = 3; exp_rep = 3; streak = 0;
            end else if (nbad == 0) begin
               exp_state = 0; exp_rep = 3; streak = 0;
            end else begin
               streak    = (exp_state == 1 && who == exp_rep) ? streak + 1 : 1;
               exp_rep   = who;
               exp_state = (streak >= P) ? 2 : 1;
            end
         end
      end
      p_vld  = in_valid;
      p_w[0] = ori_z;
      p_w[1] = mai_z;
      p_w[2] = men_z;
      p_m    = MASK_EN ? care_mask : '1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_all();
      chk("out_valid",   32'(out_valid),   32'(exp_ov));
      chk("z",           32'(z),           32'(exp_z));
      chk("mism",        32'(mism),        32'(exp_mism));
      chk("err_ori",     32'(err_ori),     32'(exp_err[0]));
      chk("err_mai",     32'(err_mai),     32'(exp_err[1]));
      chk("err_men",     32'(err_men),     32'(exp_err[2]));
      chk("fault_state", 32'(fault_state), 32'(exp_state));
      chk("fault_rep",   32'(fault_rep),   32'(exp_rep));
   endtask

   task automatic step(input bit v, input logic [W-1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] e, input bit c, input logic [W-1:0] m);
      in_valid  = v;
      ori_z     = o;
      mai_z     = a;
      men_z     = e;
      clr       = c;
      care_mask = m;
      @(posedge clk);
      #1;
      model_edge(c);
      check_all();
   endtask

   task automatic apply_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      clr      = 1'b0;
      #2;
      p_vld = 1'b0; exp_ov = 1'b0; exp_z = '0; exp_mism = '0;
      model_health_clear();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [W-1:0] base;
      for (int r = 0; r < 3; r++) begin
         exp_err[r] = 0;
         p_w[r] = '0;
      end
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;

      // Clean words: result lands two edges after drive.
      for (int i = 0; i < 5; i++) step(1, 10'h155, 10'h155, 10'h155, 0, '1);
      step(0, '0, '0, '0, 0, '1);
      step(0, '0, '0, '0, 0, '1);

      // mai persistently wrong -> SUSPECT then FAULT after PERSIST samples.
      for (int i = 0; i < P; i++) step(1, 10'h155, 10'h154, 10'h155, 0, '1);
      step(0, '0, '0, '0, 0, '1);
      step(0, '0, '0, '0, 0, '1);
      chk("fault_after_persist", 32'(fault_state), 32'd2);
      chk("err_mai_persist",     32'(err_mai),     32'(P));

      // Suspect hand-over ori -> men, then recovery.
      step(0, '0, '0, '0, 1, '1);
      step(1, 10'h0AA, 10'h155, 10'h155, 0, '1);
      step(1, 10'h155, 10'h155, 10'h3FF, 0, '1);
      step(1, 10'h155, 10'h155, 10'h155, 0, '1);
      step(0, '0, '0, '0, 0, '1);
      step(0, '0, '0, '0, 0, '1);

      // Two replicas disagree -> MULTI, sticky through clean samples until clr.
      step(1, 10'h001, 10'h002, 10'h000, 0, '1);
      for (int i = 0; i < 3; i++) step(1, 10'h155, 10'h155, 10'h155, 0, '1);
      step(0, '0, '0, '0, 0, '1);
      chk("multi_sticky", 32'(fault_state), 32'd3);
      step(0, '0, '0, '0, 1, '1);
      step(1, 10'h155, 10'h155, 10'h155, 0, '1);
      step(0, '0, '0, '0, 0, '1);

      // Counter saturation, then reset with samples in flight.
      step(0, '0, '0, '0, 1, '1);
      for (int i = 0; i < 300; i++) step(1, 10'h155, 10'h155, 10'h0F0, 0, '1);
      chk("err_men_sat", 32'(err_men), 32'd255);
      apply_reset();
      step(0, '0, '0, '0, 0, '1);
      step(1, 10'h2A5, 10'h2A5, 10'h2A5, 0, '1);
      step(0, '0, '0, '0, 0, '1);

      if (MASK_EN) begin
         step(0, '0, '0, '0, 1, 10'h3FE);
         step(1, 10'h155, 10'h155, 10'h154, 0, 10'h3FE);
         step(0, '0, '0, '0, 0, 10'h3FE);
      end

      // Random traffic with bubbles, sporadic faults and occasional clr.
      for (int i = 0; i < 600; i++) begin
         base = W'($urandom);
         step($urandom_range(0, 9) < 7,
              base ^ flip_maybe(), base ^ flip_maybe(), base ^ flip_maybe(),
              $urandom_range(0, 39) == 0, MASK_EN ? W'($urandom) : '1);
      end
      step(0, '0, '0, '0, 0, '1);
      step(0, '0, '0, '0, 0, '1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
